// File: rtl/fb_text_writer.sv
// fb_text_writer: packs a character stream into glyph-pair words of the
// text-mode frame buffer and writes them in this block's arbiter slot.
// Ports: clk, rst (sync, active-low), acnt (arbiter count),
//   ch_data/ch_valid/ch_ready (character handshake),
//   mem_addr/mem_wdata/mem_we (frame buffer write port), busy.
// Option: define FB_ROW_AUTOCLEAR_EN to blank each new row on advance.
module fb_text_writer #(
  parameter logic [15:0] FB_BASE       = 16'hFB50,
  parameter int          WORDS_PER_ROW = 40,
  parameter int          ROWS          = 30,
  parameter logic [2:0]  SLOT          = 3'd4,
  parameter logic [7:0]  BLANK         = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  acnt,
  input  logic [7:0]  ch_data,
  input  logic        ch_valid,
  output logic        ch_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        busy
);

  localparam logic [15:0] WPR      = 16'(WORDS_PER_ROW);
  localparam logic [6:0]  COL_LAST = 7'(2 * WORDS_PER_ROW - 1);
  localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
  localparam logic [10:0] CLR_LAST = 11'(WORDS_PER_ROW * ROWS - 1);
  localparam logic [10:0] RCL_LAST = 11'(WORDS_PER_ROW - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    CLR
`ifdef FB_ROW_AUTOCLEAR_EN
    , RCLR
`endif
  } state_t;

`ifdef FB_ROW_AUTOCLEAR_EN
  localparam state_t ADV_ST = RCLR;
`else
  localparam state_t ADV_ST = IDLE;
`endif

  state_t state, state_nx;

  logic [6:0]  col;
  logic [4:0]  row;
  logic [15:0] wptr;
  logic [15:0] row_base;
  logic [7:0]  hold;
  logic        nl;
  logic [10:0] cnt;

  logic        slot;
  logic        accept;
  logic        is_nl;
  logic        is_ff;
  logic        adv;
  logic [4:0]  next_row;
  logic [15:0] next_base;

  assign slot   = (acnt == SLOT);
  assign accept = ch_valid && (state == IDLE);
  assign is_nl  = (ch_data == 8'h0A);
  assign is_ff  = (ch_data == 8'h0C);

  // Row starts are tracked incrementally; wrap goes back to the base.
  assign next_row  = (row == ROW_LAST) ? 5'd0 : row + 5'd1;
  assign next_base = (row == ROW_LAST) ? FB_BASE : row_base + WPR;

  assign adv = (accept && is_nl && !col[0])
             || (state == WR && slot && (col == COL_LAST || nl));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ch_ready = 1'b0;
    busy     = 1'b1;
    mem_we   = 1'b0;
    unique case (state)
      IDLE: begin
        ch_ready = 1'b1;
        busy     = 1'b0;
        if (accept) begin
          unique case (1'b1)
            is_ff:   state_nx = CLR;
            is_nl:   state_nx = col[0] ? WR : ADV_ST;
            default: state_nx = col[0] ? WR : IDLE;
          endcase
        end
      end
      WR: begin
        mem_we = slot;
        if (slot) state_nx = adv ? ADV_ST : IDLE;
      end
      CLR: begin
        mem_we = slot;
        if (slot && cnt == CLR_LAST) state_nx = IDLE;
      end
`ifdef FB_ROW_AUTOCLEAR_EN
      RCLR: begin
        mem_we = slot;
        if (slot && cnt == RCL_LAST) state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col       <= 7'd0;
      row       <= 5'd0;
      wptr      <= FB_BASE;
      row_base  <= FB_BASE;
      hold      <= BLANK;
      nl        <= 1'b0;
      cnt       <= 11'd0;
      mem_addr  <= FB_BASE;
      mem_wdata <= 16'h0000;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_ff: begin
                hold      <= BLANK;
                nl        <= 1'b0;
                cnt       <= 11'd0;
                mem_addr  <= FB_BASE;
                mem_wdata <= {BLANK, BLANK};
              end
              is_nl: begin
                if (col[0]) begin
                  mem_wdata <= {hold, BLANK};
                  mem_addr  <= wptr;
                  nl        <= 1'b1;
                end
              end
              default: begin
                if (col[0]) begin
                  mem_wdata <= {hold, ch_data};
                  mem_addr  <= wptr;
                  nl        <= 1'b0;
                end else begin
                  hold <= ch_data;
                  col  <= col + 7'd1;
                end
              end
            endcase
          end
        end
        WR: begin
          if (slot) begin
            nl <= 1'b0;
            if (!adv) begin
              col  <= col + 7'd1;
              wptr <= wptr + 16'd1;
            end
          end
        end
        CLR: begin
          // Count words rather than compare addresses: the last word
          // sits at 0xFFFF and the address would wrap.
          if (slot) begin
            if (cnt == CLR_LAST) begin
              col      <= 7'd0;
              row      <= 5'd0;
              wptr     <= FB_BASE;
              row_base <= FB_BASE;
            end else begin
              cnt      <= cnt + 11'd1;
              mem_addr <= mem_addr + 16'd1;
            end
          end
        end
`ifdef FB_ROW_AUTOCLEAR_EN
        RCLR: begin
          if (slot && cnt != RCL_LAST) begin
            cnt      <= cnt + 11'd1;
            mem_addr <= mem_addr + 16'd1;
          end
        end
`endif
        default: ;
      endcase

      if (adv) begin
        col      <= 7'd0;
        row      <= next_row;
        wptr     <= next_base;
        row_base <= next_base;
`ifdef FB_ROW_AUTOCLEAR_EN
        cnt       <= 11'd0;
        mem_addr  <= next_base;
        mem_wdata <= {BLANK, BLANK};
`endif
      end
    end
  end

endmodule
